// File: rtl/lnnae_sequencer_if.sv
// Job, array and result signals of the LNNAE sequencer.
// master = sequencer side; slave = job source, systolic array and result sink.
interface lnnae_sequencer_if #(
    parameter int N  = 4,
    parameter int CW = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [N*N-1:0]   in_matrix;
    logic             arr_loading;
    logic             arr_enable;
    logic             arr_shiftdirection;
    logic [0:N-1]     arr_datain;
    logic [CW-1:0]    arr_count;
    logic             res_valid;
    logic             res_ready;
    logic [CW-1:0]    res_count;
    logic [15:0]      perf_jobs;

    modport master (
        input  in_valid, in_matrix, arr_count, res_ready,
        output in_ready, arr_loading, arr_enable, arr_shiftdirection, arr_datain,
               res_valid, res_count, perf_jobs
    );

    modport slave (
        output in_valid, in_matrix, arr_count, res_ready,
        input  in_ready, arr_loading, arr_enable, arr_shiftdirection, arr_datain,
               res_valid, res_count, perf_jobs
    );
endinterface

// File: rtl/lnnae_sequencer.sv
// LNNAE systolic-array sequencer: load a job matrix, run the CNOT schedule, return the count.
// Optional completed-job counter enabled by defining LNNAE_SEQ_PERF_EN.
module lnnae_sequencer #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic                clock,
    input  logic                reset,
    lnnae_sequencer_if.master   bus
);
    localparam int RW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        CAPT,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [RW-1:0]   r_row;
    logic [RW-1:0]   w_nextRow;
    logic [RW-1:0]   r_step;
    logic [RW-1:0]   w_nextStep;
    logic [RW-1:0]   r_pass;
    logic [RW-1:0]   w_nextPass;
    logic            r_horiz;
    logic            w_nextHoriz;
    logic [N*N-1:0]  r_matrix;
    logic [N*N-1:0]  w_nextMatrix;
    logic [N-1:0]    w_rowBits;
    logic [0:N-1]    w_nextDatain;

    // Outputs are derived from next-state values so every output is a flop.
    always_comb begin
        w_nextState  = r_state;
        w_nextRow    = '0;
        w_nextStep   = '0;
        w_nextPass   = '0;
        w_nextHoriz  = 1'b0;
        w_nextMatrix = r_matrix;
        w_rowBits    = '0;
        w_nextDatain = '0;

        unique case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_nextState  = LOAD;
                    w_nextMatrix = bus.in_matrix;
                end
            end
            LOAD: begin
                if (r_row == RW'(N - 1)) begin
                    w_nextState = CALC;
                end else begin
                    w_nextRow = r_row + 1'b1;
                end
            end
            CALC: begin
                w_nextPass  = r_pass;
                w_nextHoriz = r_horiz;
                if (r_step == RW'(N - 2)) begin
                    w_nextHoriz = ~r_horiz;
                    // A pass ends after its horizontal half.
                    if (r_horiz) begin
                        if (r_pass == RW'(N - 2)) begin
                            w_nextState = CAPT;
                            w_nextPass  = '0;
                        end else begin
                            w_nextPass = r_pass + 1'b1;
                        end
                    end
                end else begin
                    w_nextStep = r_step + 1'b1;
                end
            end
            CAPT: begin
                w_nextState = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        w_rowBits = w_nextMatrix[N*int'(w_nextRow) +: N];
        for (int c = 0; c < N; c++) begin
            w_nextDatain[c] = (w_nextState == LOAD) ? w_rowBits[c] : 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state                <= IDLE;
            r_row                  <= '0;
            r_step                 <= '0;
            r_pass                 <= '0;
            r_horiz                <= 1'b0;
            r_matrix               <= '0;
            bus.in_ready           <= 1'b1;
            bus.arr_loading        <= 1'b0;
            bus.arr_enable         <= 1'b0;
            bus.arr_shiftdirection <= 1'b1;
            bus.arr_datain         <= '0;
            bus.res_valid          <= 1'b0;
            bus.res_count          <= '0;
        end else begin
            r_state                <= w_nextState;
            r_row                  <= w_nextRow;
            r_step                 <= w_nextStep;
            r_pass                 <= w_nextPass;
            r_horiz                <= w_nextHoriz;
            r_matrix               <= w_nextMatrix;
            bus.in_ready           <= (w_nextState == IDLE);
            bus.arr_loading        <= (w_nextState == LOAD);
            bus.arr_enable         <= (w_nextState == CALC);
            bus.arr_shiftdirection <= (w_nextState == CALC) ? ~w_nextHoriz : 1'b1;
            bus.arr_datain         <= w_nextDatain;
            bus.res_valid          <= (w_nextState == DONE);
            if (r_state == CAPT) begin
                bus.res_count <= bus.arr_count;
            end
        end
    end

`ifdef LNNAE_SEQ_PERF_EN
    logic [15:0] r_perfJobs;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perfJobs <= '0;
        end else if (bus.res_valid && bus.res_ready && (r_perfJobs != 16'hFFFF)) begin
            r_perfJobs <= r_perfJobs + 16'd1;
        end
    end

    assign bus.perf_jobs = r_perfJobs;
`else
    assign bus.perf_jobs = 16'h0000;
`endif

endmodule

// File: tb/tb_lnnae_sequencer.sv
// Self-checking bench for lnnae_sequencer with a stub array holding arr_count constant.
// Honours LNNAE_SEQ_PERF_EN when predicting perf_jobs.
module tb_lnnae_sequencer;
    localparam int N     = 4;
    localparam int CW    = 8;
    localparam int CALCC = 2 * (N - 1) * (N - 1);
    localparam int LAT   = N + CALCC + 1;
    localparam int VW    = N + 5;

    typedef struct {
        logic [N*N-1:0]        matrix;
        logic [CW-1:0]         count;
        int                    delay;
        logic [N-1:0][N-1:0]   expRows;
        logic [CW-1:0]         expRes;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   numChecks = 0;
    int   numFails  = 0;
    int   expJobs   = 0;

    lnnae_sequencer_if #(.N(N), .CW(CW)) bus ();

    lnnae_sequencer #(.N(N), .CW(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [N-1:0] dataRow();
        logic [N-1:0] r;
        for (int c = 0; c < N; c++) r[c] = bus.arr_datain[c];
        return r;
    endfunction

    function automatic logic [VW-1:0] actVec();
        return {bus.in_ready, bus.arr_loading, bus.arr_enable, bus.arr_shiftdirection,
                bus.res_valid, dataRow()};
    endfunction

    // Reference: t counts edges since the accept edge (t=0 is the first LOAD cycle).
    function automatic logic [VW-1:0] expCtrl(input int t, input logic [N-1:0][N-1:0] rows);
        logic ld, en, dir;
        logic [N-1:0] row;
        int p;
        ld = 1'b0; en = 1'b0; dir = 1'b1; row = '0;
        if (t < N) begin
            ld  = 1'b1;
            row = rows[t];
        end else if (t < N + CALCC) begin
            en  = 1'b1;
            p   = (t - N) % (2 * (N - 1));
            dir = (p < N - 1);
        end
        return {1'b0, ld, en, dir, 1'b0, row};
    endfunction

    function automatic logic [15:0] expPerf();
`ifdef LNNAE_SEQ_PERF_EN
        return 16'(expJobs);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic checkIdle(input string name);
        checkOutput(name, 32'({actVec(), bus.res_count, bus.perf_jobs}),
                    32'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {N{1'b0}}, {CW{1'b0}}, 16'h0000}));
    endtask

    task automatic applyStimulus(input logic [N*N-1:0] m, input logic [CW-1:0] cnt, input int delay,
                                 input logic [N-1:0][N-1:0] rows, input logic [CW-1:0] expRes,
                                 input string tag);
        int waitCycles;
        waitCycles = 0;
        bus.arr_count = cnt;
        bus.in_matrix = m;
        bus.in_valid  = 1'b1;
        bus.res_ready = (delay == 0);
        while (!bus.in_ready && waitCycles < 100) begin
            tick();
            waitCycles++;
        end
        if (!bus.in_ready) begin
            checkOutput({tag, " accept timeout"}, 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        tick();
        bus.in_valid  = 1'b0;
        bus.in_matrix = ~m;
        for (int t = 0; t < LAT; t++) begin
            checkOutput($sformatf("%s trace t=%0d", tag, t), 32'(actVec()), 32'(expCtrl(t, rows)));
            tick();
        end
        checkOutput({tag, " result"}, 32'({bus.res_valid, bus.in_ready, bus.res_count}),
                    32'({1'b1, 1'b0, expRes}));
        for (int d = 0; d < delay; d++) begin
            tick();
            checkOutput($sformatf("%s hold d=%0d", tag, d),
                        32'({bus.res_valid, bus.in_ready, bus.res_count}), 32'({1'b1, 1'b0, expRes}));
        end
        bus.res_ready = 1'b1;
        tick();
        expJobs++;
        checkOutput({tag, " release"}, 32'({bus.res_valid, bus.in_ready}), 32'({1'b0, 1'b1}));
        checkOutput({tag, " perf_jobs"}, 32'(bus.perf_jobs), 32'(expPerf()));
    endtask

    initial begin
        vec_t                vecs[4];
        logic [N*N-1:0]      m;
        logic [N-1:0][N-1:0] rows;
        logic [CW-1:0]       cnt;
        bit                  sawValid;
        int acc, res, overlap, lastAcc, minGap, badCount;

        vecs[0] = '{matrix: 16'h8421, count: 8'd37,  delay: 0,  expRows: {4'h8, 4'h4, 4'h2, 4'h1}, expRes: 8'd37};
        vecs[1] = '{matrix: 16'h8421, count: 8'd37,  delay: 50, expRows: {4'h8, 4'h4, 4'h2, 4'h1}, expRes: 8'd37};
        vecs[2] = '{matrix: 16'h1234, count: 8'hFF,  delay: 3,  expRows: {4'h1, 4'h2, 4'h3, 4'h4}, expRes: 8'hFF};
        vecs[3] = '{matrix: 16'hF0A5, count: 8'h00,  delay: 1,  expRows: {4'hF, 4'h0, 4'hA, 4'h5}, expRes: 8'h00};

        bus.in_valid  = 1'b0;
        bus.in_matrix = '0;
        bus.arr_count = '0;
        bus.res_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            checkIdle($sformatf("idle c=%0d", i));
            tick();
        end

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].matrix, vecs[i].count, vecs[i].delay, vecs[i].expRows,
                          vecs[i].expRes, $sformatf("vec%0d", i));
        end

        for (int j = 0; j < 6; j++) begin
            m   = N*N'($urandom);
            cnt = CW'($urandom);
            for (int r = 0; r < N; r++) rows[r] = N'(m >> (N * r));
            applyStimulus(m, cnt, int'($urandom_range(0, 3)), rows, cnt, $sformatf("rand%0d", j));
        end

        // Reset in CALC cycle 7 drops the job.
        bus.arr_count = 8'd37;
        bus.in_matrix = 16'h8421;
        bus.in_valid  = 1'b1;
        bus.res_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int t = 0; t < N + 7; t++) tick();
        checkOutput("calc7 enable", 32'(bus.arr_enable), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expJobs = 0;
        checkIdle("after mid reset");
        sawValid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.res_valid) sawValid = 1'b1;
            tick();
        end
        checkOutput("dropped job no result", 32'(sawValid), 32'd0);
        applyStimulus(16'h8421, 8'd37, 0, {4'h8, 4'h4, 4'h2, 4'h1}, 8'd37, "post reset");

        // Three back-to-back jobs with in_valid held high.
        acc = 0; res = 0; overlap = 0; lastAcc = -1; minGap = 1000; badCount = 0;
        bus.arr_count = 8'd55;
        bus.in_matrix = 16'hBEEF;
        bus.res_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (bus.arr_loading && bus.arr_enable) overlap++;
            if (bus.res_valid && bus.res_ready) begin
                res++;
                if (bus.res_count !== 8'd55) badCount++;
            end
            if (bus.in_ready && bus.in_valid) begin
                acc++;
                if (lastAcc >= 0 && cyc - lastAcc < minGap) minGap = cyc - lastAcc;
                lastAcc = cyc;
            end
            tick();
            if (acc == 3) bus.in_valid = 1'b0;
        end
        expJobs += 3;
        checkOutput("b2b results", 32'(res), 32'd3);
        checkOutput("b2b load/enable overlap", 32'(overlap), 32'd0);
        checkOutput("b2b result values", 32'(badCount), 32'd0);
        checkOutput("b2b throughput", 32'(minGap >= N + CALCC + 3), 32'd1);
        checkOutput("b2b perf_jobs", 32'(bus.perf_jobs), 32'(expPerf()));

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end
endmodule
